spdif_frame_fifo: RTL and testbench
===================================

Name: spdif_frame_fifo

Overview:
- Sits directly downstream of the S/PDIF receiver.
- Consumes its per-subframe sample/ack stream, lrck, lock and rate outputs, and pairs left/right subframes into stereo frames tagged with the current rate.
- Buffers frames in a small first-word-fall-through FIFO toward the mixer over a valid/ready handshake.
- Flushes and resynchronises on any lock loss or receiver resync pulse.

Parameters:
- DEPTH_LOG2, 3, log2 of FIFO depth in frames (depth = 8).
- NUM_RATE, 5, width of the one-hot rate tag; matches the receiver's rate output.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- data_i  in  24  subframe sample from receiver.
- ack_i  in  1  one-cycle strobe; data_i/lrck_i valid this cycle.
- lrck_i  in  1  channel of the strobed subframe: 1 = left, 0 = right.
- locked_i  in  1  receiver lock.
- resync_i  in  1  one-cycle pulse on lock acquisition (receiver rst_o).
- rate_i  in  NUM_RATE  one-hot rate from receiver.
- frame_valid_o  out  1  FIFO head valid.
- frame_ready_i  in  1  consumer accepts head when valid and ready.
- left_o  out  24  head left sample.
- right_o  out  24  head right sample.
- rate_o  out  NUM_RATE  rate tag of head frame.
- overflow_o  out  1  sticky: a frame was dropped because the FIFO was full.
- misalign_o  out  1  sticky: an unpaired subframe was discarded.
- level_o  out  DEPTH_LOG2+1  fill level (optional feature).

Behaviour:
- Reset (async, rst=1): pairing FSM = WAIT_L; FIFO empty; frame_valid_o=0; left_o/right_o/rate_o=0; overflow_o=0; misalign_o=0; level_o=0.
- Pairing FSM, states WAIT_L and HAVE_L. Only cycles with ack_i=1 and locked_i=1 advance it.
  - WAIT_L, lrck_i=1: latch data_i into the left holding register, go to HAVE_L.
  - WAIT_L, lrck_i=0: discard the subframe, set misalign_o, stay in WAIT_L.
  - HAVE_L, lrck_i=0: form frame {left hold, data_i, rate_i}, push it, go to WAIT_L.
  - HAVE_L, lrck_i=1: overwrite left hold with data_i, set misalign_o, stay in HAVE_L.
- Flush: when locked_i=0 or resync_i=1, the next cycle has FSM=WAIT_L, FIFO empty, frame_valid_o=0.
  - Any ack_i in a flush cycle is ignored.
  - Sticky flags are not cleared by a flush.
- FIFO:
  - Storage is DEPTH_LOG2-bit read/write pointers plus a (DEPTH_LOG2+1)-bit count; pointers wrap modulo depth.
  - Push on a right-channel ack makes the frame visible at the head one cycle later (frame_valid_o=1 the cycle after the right ack) when the FIFO was empty.
  - Pop occurs when frame_valid_o && frame_ready_i. The next entry, if any, is presented the following cycle.
  - frame_ready_i while frame_valid_o=0 has no effect.
  - Outputs are stable while valid=1 and ready=0.
  - Push and pop in the same cycle: both occur and the count is unchanged. This holds when full; the push is accepted because the pop frees a slot.
  - Push while full with no pop: the frame is dropped, overflow_o is set, and the FSM still returns to WAIT_L.
  - Pop when empty is impossible (valid=0).
- Sticky flags overflow_o and misalign_o clear only on rst.

Optional Feature:
- Macro: SPDIF_FRAME_FIFO_LEVEL_EN.
- Defined: level_o reports the live FIFO count, 0..2^DEPTH_LOG2, updated the same cycle as the internal count.
- Not defined: level_o is tied to 0 and no extra logic is generated. The port is present in both builds.

Test Plan:
- Reset, then locked_i=1 with ack pairs (L=0x123456, R=0xABCDEF), rate_i=5'b00100, ready=1 -> frame_valid_o=1 one cycle after the R ack; left_o=0x123456, right_o=0xABCDEF, rate_o=5'b00100; popped the same cycle.
- Stream starts with an R ack (0x000001), then L=0x000002, R=0x000003 -> misalign_o=1; first frame is {0x000002, 0x000003}.
- L, L, R acks (0x11, 0x22, 0x33) -> single frame {0x22, 0x33}; misalign_o=1.
- ready=0; push 9 frames into a depth-8 FIFO -> overflow_o=1 after the 9th; level_o=8 with the macro; then ready=1 -> exactly 8 frames in order, the 9th is absent.
- Full FIFO, ready=1 held while a new R ack arrives in the pop cycle -> level stays 8, no overflow, new frame appears last.
- FIFO holding 3 frames and FSM in HAVE_L; drop locked_i for 1 cycle (or pulse resync_i) -> next cycle valid=0 and level=0; the next R ack is discarded with misalign_o=1; pairing restarts at WAIT_L.

Source files
------------

// File: rtl/spdif_frame_fifo.sv
// rtl/spdif_frame_fifo.sv - pairs S/PDIF subframes into rate-tagged stereo frames and buffers them in a FWFT FIFO
//
// Optional feature macro: SPDIF_FRAME_FIFO_LEVEL_EN (level_o reports the live fill count; tied to 0 otherwise)
//
// Ports:
//   clk, rst                  single clock, asynchronous active-high reset
//   data_i, ack_i, lrck_i     per-subframe sample stream from the receiver (lrck_i: 1 = left, 0 = right)
//   locked_i, resync_i        receiver lock and lock-acquisition pulse; loss of lock or resync flushes
//   rate_i                    one-hot rate, captured into the frame on the right-channel ack
//   frame_valid_o/ready_i     head-of-FIFO handshake toward the mixer
//   left_o, right_o, rate_o   head frame contents (zero while empty)
//   overflow_o, misalign_o    sticky error flags, cleared only by rst
//   level_o                   FIFO fill level (optional)
module spdif_frame_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter int NUM_RATE   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [23:0]           data_i,
    input  logic                  ack_i,
    input  logic                  lrck_i,
    input  logic                  locked_i,
    input  logic                  resync_i,
    input  logic [NUM_RATE-1:0]   rate_i,
    output logic                  frame_valid_o,
    input  logic                  frame_ready_i,
    output logic [23:0]           left_o,
    output logic [23:0]           right_o,
    output logic [NUM_RATE-1:0]   rate_o,
    output logic                  overflow_o,
    output logic                  misalign_o,
    output logic [DEPTH_LOG2:0]   level_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int FW    = 48 + NUM_RATE;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2+1)'(DEPTH);

    typedef enum logic {WAIT_L, HAVE_L} state_t;

    state_t                state, next_state;
    logic [23:0]           left_hold;
    logic                  flush, adv;
    logic                  push, load_left, set_misalign;
    logic                  pop, full, wr_en;
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [FW-1:0]         mem [DEPTH];
    logic [FW-1:0]         head;

    // Flush takes priority over everything, including a coincident ack.
    assign flush = !locked_i || resync_i;
    assign adv   = ack_i && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        state <= WAIT_L;
        else if (flush) state <= WAIT_L;
        else            state <= next_state;
    end

    always_comb begin
        next_state   = state;
        push         = 1'b0;
        load_left    = 1'b0;
        set_misalign = 1'b0;
        if (adv) begin
            case (state)
                WAIT_L: begin
                    if (lrck_i) begin
                        load_left  = 1'b1;
                        next_state = HAVE_L;
                    end else begin
                        set_misalign = 1'b1;
                    end
                end
                HAVE_L: begin
                    if (!lrck_i) begin
                        push       = 1'b1;
                        next_state = WAIT_L;
                    end else begin
                        // A second left replaces the first; the older one is the orphan.
                        load_left    = 1'b1;
                        set_misalign = 1'b1;
                    end
                end
                default: next_state = WAIT_L;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            left_hold <= '0;
        else if (load_left) left_hold <= data_i;
    end

    assign pop  = frame_valid_o && frame_ready_i;
    assign full = (count == FULL_COUNT);
    // When full, a simultaneous pop frees the slot being written (wr_ptr == rd_ptr).
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {left_hold, data_i, rate_i};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
            misalign_o <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (wr_en) wr_ptr <= wr_ptr + 1'b1;
                if (pop)   rd_ptr <= rd_ptr + 1'b1;
                case ({wr_en, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
            if (push && !wr_en) overflow_o <= 1'b1;
            if (set_misalign)   misalign_o <= 1'b1;
        end
    end

    assign head          = mem[rd_ptr];
    assign frame_valid_o = (count != '0);
    assign left_o        = frame_valid_o ? head[FW-1 -: 24]        : '0;
    assign right_o       = frame_valid_o ? head[NUM_RATE +: 24]    : '0;
    assign rate_o        = frame_valid_o ? head[NUM_RATE-1:0]      : '0;

`ifdef SPDIF_FRAME_FIFO_LEVEL_EN
    assign level_o = count;
`else
    assign level_o = '0;
`endif

endmodule

// File: tb/tb_spdif_frame_fifo.sv
// tb/tb_spdif_frame_fifo.sv - directed self-checking bench for spdif_frame_fifo
module tb_spdif_frame_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] data_i;
    logic        ack_i;
    logic        lrck_i;
    logic        locked_i;
    logic        resync_i;
    logic [4:0]  rate_i;
    logic        frame_valid_o;
    logic        frame_ready_i;
    logic [23:0] left_o;
    logic [23:0] right_o;
    logic [4:0]  rate_o;
    logic        overflow_o;
    logic        misalign_o;
    logic [3:0]  level_o;

    int checks = 0;
    int errors = 0;

    spdif_frame_fifo #(.DEPTH_LOG2(3), .NUM_RATE(5)) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .ack_i(ack_i), .lrck_i(lrck_i),
        .locked_i(locked_i), .resync_i(resync_i), .rate_i(rate_i),
        .frame_valid_o(frame_valid_o), .frame_ready_i(frame_ready_i),
        .left_o(left_o), .right_o(right_o), .rate_o(rate_o),
        .overflow_o(overflow_o), .misalign_o(misalign_o), .level_o(level_o)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_level(input int n);
`ifdef SPDIF_FRAME_FIFO_LEVEL_EN
        return 4'(n);
`else
        return 4'(0 * n);
`endif
    endfunction

    task automatic send(input logic lr, input logic [23:0] d);
        ack_i  = 1'b1;
        lrck_i = lr;
        data_i = d;
        tick();
        ack_i  = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [23:0] l, input logic [23:0] r, input logic [4:0] rt);
        check({tag, "_valid"}, 64'(frame_valid_o), 64'(1));
        check({tag, "_left"},  64'(left_o),  64'(l));
        check({tag, "_right"}, 64'(right_o), 64'(r));
        check({tag, "_rate"},  64'(rate_o),  64'(rt));
    endtask

    task automatic pop_head(input string tag, input logic [23:0] l, input logic [23:0] r, input logic [4:0] rt);
        check_head(tag, l, r, rt);
        frame_ready_i = 1'b1;
        tick();
        frame_ready_i = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; data_i = '0; ack_i = 1'b0; lrck_i = 1'b0; locked_i = 1'b0;
        resync_i = 1'b0; rate_i = '0; frame_ready_i = 1'b0;
        #1;
        check("rst_valid",    64'(frame_valid_o), 64'(0));
        check("rst_left",     64'(left_o),        64'(0));
        check("rst_right",    64'(right_o),       64'(0));
        check("rst_rate",     64'(rate_o),        64'(0));
        check("rst_overflow", 64'(overflow_o),    64'(0));
        check("rst_misalign", 64'(misalign_o),    64'(0));
        check("rst_level",    64'(level_o),       64'(0));
        tick();
        rst = 1'b0;
        locked_i = 1'b1;
        rate_i = 5'b00100;
        frame_ready_i = 1'b1;
        tick();

        // Basic pair, popped the cycle it appears
        send(1'b1, 24'h123456);
        check("basic_not_yet_valid", 64'(frame_valid_o), 64'(0));
        send(1'b0, 24'hABCDEF);
        check_head("basic", 24'h123456, 24'hABCDEF, 5'b00100);
        check("basic_level", 64'(level_o), 64'(exp_level(1)));
        tick();
        check("basic_popped", 64'(frame_valid_o), 64'(0));
        check("basic_misalign", 64'(misalign_o), 64'(0));
        frame_ready_i = 1'b0;

        // Stream starting on a right subframe
        do_reset();
        send(1'b0, 24'h000001);
        check("rfirst_misalign", 64'(misalign_o), 64'(1));
        check("rfirst_valid", 64'(frame_valid_o), 64'(0));
        send(1'b1, 24'h000002);
        send(1'b0, 24'h000003);
        pop_head("rfirst", 24'h000002, 24'h000003, 5'b00100);
        check("rfirst_empty", 64'(frame_valid_o), 64'(0));

        // L, L, R
        do_reset();
        send(1'b1, 24'h000011);
        check("llr_misalign0", 64'(misalign_o), 64'(0));
        send(1'b1, 24'h000022);
        check("llr_misalign1", 64'(misalign_o), 64'(1));
        send(1'b0, 24'h000033);
        pop_head("llr", 24'h000022, 24'h000033, 5'b00100);
        check("llr_single", 64'(frame_valid_o), 64'(0));

        // Overflow: nine frames into depth eight
        do_reset();
        rate_i = 5'b00001;
        for (int k = 0; k < 9; k++) begin
            send(1'b1, 24'(24'h000100 + k));
            send(1'b0, 24'(24'h000200 + k));
            if (k == 7) begin
                check("ovf_level8", 64'(level_o), 64'(exp_level(8)));
                check("ovf_not_yet", 64'(overflow_o), 64'(0));
            end
        end
        check("ovf_flag", 64'(overflow_o), 64'(1));
        check("ovf_level_after", 64'(level_o), 64'(exp_level(8)));
        for (int k = 0; k < 8; k++)
            pop_head($sformatf("ovf_pop%0d", k), 24'(24'h000100 + k), 24'(24'h000200 + k), 5'b00001);
        check("ovf_ninth_absent", 64'(frame_valid_o), 64'(0));

        // Full FIFO with push and pop in the same cycle
        do_reset();
        rate_i = 5'b00010;
        for (int k = 0; k < 8; k++) begin
            send(1'b1, 24'(24'h000400 + k));
            send(1'b0, 24'(24'h000500 + k));
        end
        send(1'b1, 24'h000300);
        check_head("fullpp_head0", 24'h000400, 24'h000500, 5'b00010);
        rate_i = 5'b01000;
        frame_ready_i = 1'b1;
        send(1'b0, 24'h000301);
        frame_ready_i = 1'b0;
        check("fullpp_overflow", 64'(overflow_o), 64'(0));
        check("fullpp_level", 64'(level_o), 64'(exp_level(8)));
        for (int k = 1; k < 8; k++)
            pop_head($sformatf("fullpp_pop%0d", k), 24'(24'h000400 + k), 24'(24'h000500 + k), 5'b00010);
        pop_head("fullpp_last", 24'h000300, 24'h000301, 5'b01000);
        check("fullpp_empty", 64'(frame_valid_o), 64'(0));

        // Flush on lock loss with FIFO holding three frames and FSM in HAVE_L
        do_reset();
        rate_i = 5'b10000;
        for (int k = 0; k < 3; k++) begin
            send(1'b1, 24'(24'h000600 + k));
            send(1'b0, 24'(24'h000700 + k));
        end
        send(1'b1, 24'h0000AA);
        check("flush_pre_level", 64'(level_o), 64'(exp_level(3)));
        check("flush_pre_misalign", 64'(misalign_o), 64'(0));
        locked_i = 1'b0;
        tick();
        locked_i = 1'b1;
        check("flush_valid", 64'(frame_valid_o), 64'(0));
        check("flush_level", 64'(level_o), 64'(exp_level(0)));
        check("flush_left_zero", 64'(left_o), 64'(0));
        send(1'b0, 24'h000055);
        check("flush_r_misalign", 64'(misalign_o), 64'(1));
        check("flush_r_dropped", 64'(frame_valid_o), 64'(0));
        send(1'b1, 24'h000066);
        send(1'b0, 24'h000077);
        check_head("flush_restart", 24'h000066, 24'h000077, 5'b10000);

        // Resync pulse with a coincident right ack that must be ignored
        send(1'b1, 24'h000088);
        resync_i = 1'b1;
        send(1'b0, 24'h000099);
        resync_i = 1'b0;
        check("resync_valid", 64'(frame_valid_o), 64'(0));
        check("resync_level", 64'(level_o), 64'(exp_level(0)));
        check("resync_sticky", 64'(misalign_o), 64'(1));
        send(1'b1, 24'h00000A);
        send(1'b0, 24'h00000B);
        pop_head("resync_restart", 24'h00000A, 24'h00000B, 5'b10000);
        check("resync_empty", 64'(frame_valid_o), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
